// File: rtl/layer_weight_bank.sv
// Per-layer weight store: NODE_COUNT words of LANES x WEIGHT_WIDTH, valid/ready write and read streams.
// Optional per-lane even parity when LAYER_WEIGHT_PARITY_EN is defined.
module layer_weight_bank #(
   parameter int unsigned NODE_COUNT   = 784,
   parameter int unsigned LANES        = 16,
   parameter int unsigned WEIGHT_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH   = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          loadStart,
   input  logic                          sweepStart,
   input  logic                          wrValid,
   output logic                          wrReady,
   input  logic [ADDR_WIDTH-1:0]         wrAddr,
   input  logic [LANES*WEIGHT_WIDTH-1:0] wrData,
   input  logic                          wrParityFlip,
   input  logic                          rdReq,
   input  logic [ADDR_WIDTH-1:0]         rdAddr,
   output logic                          rdValid,
   input  logic                          rdReady,
   output logic [LANES*WEIGHT_WIDTH-1:0] rdData,
   output logic                          rdLast,
   output logic                          loadDone,
   output logic                          addrError,
   output logic                          busy,
   output logic                          parityError
);

   localparam int unsigned DATA_W = LANES * WEIGHT_WIDTH;
   localparam int unsigned AW1    = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0]   NODE_LIMIT = AW1'(NODE_COUNT);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NODE_COUNT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SWEEP = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic                    fetched_last_q, fetched_last_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    rd_last_q, rd_last_d;
   logic [DATA_W-1:0]       rd_data_q;
   logic                    load_done_q, load_done_d;
   logic                    addr_err_q, addr_err_d;
   logic                    busy_q, busy_d;
   logic                    wr_ready_q, wr_ready_d;

   logic                    wr_hs_c;
   logic                    out_free_c;
   logic                    wr_in_range_c;
   logic                    rd_in_range_c;
   logic                    mem_we_c;
   logic [ADDR_WIDTH-1:0]   mem_waddr_c;
   logic                    out_load_c;
   logic [ADDR_WIDTH-1:0]   out_addr_c;
   logic                    out_last_c;

   logic [DATA_W-1:0]       mem [NODE_COUNT];

   assign wr_hs_c       = wrValid && wr_ready_q;
   assign out_free_c    = !rd_valid_q || rdReady;
   assign wr_in_range_c = ({1'b0, wrAddr} < NODE_LIMIT);
   assign rd_in_range_c = ({1'b0, rdAddr} < NODE_LIMIT);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, pointer, memory write and output-register load control
   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      fetched_last_d = fetched_last_q;
      mem_we_c       = 1'b0;
      mem_waddr_c    = wrAddr;
      out_load_c     = 1'b0;
      out_addr_c     = rdAddr;
      out_last_c     = 1'b0;
      load_done_d    = 1'b0;
      addr_err_d     = 1'b0;
      rd_valid_d     = rd_valid_q;
      rd_last_d      = rd_last_q;

      case (state_q)
         S_IDLE: begin
            if (wr_hs_c) begin
               if (wr_in_range_c) begin
                  mem_we_c = 1'b1;
               end else begin
                  addr_err_d = 1'b1;
               end
            end
            if (loadStart) begin
               state_d = S_LOAD;
               ptr_d   = '0;
            end else if (sweepStart) begin
               state_d        = S_SWEEP;
               ptr_d          = '0;
               fetched_last_d = 1'b0;
               // First sweep beat is fetched now so rdValid follows sweepStart by one cycle
               if (out_free_c) begin
                  out_load_c = 1'b1;
                  out_addr_c = '0;
                  out_last_c = (LAST_ADDR == '0);
                  if (LAST_ADDR == '0) begin
                     fetched_last_d = 1'b1;
                  end else begin
                     ptr_d = ADDR_WIDTH'(1);
                  end
               end
            end
            if (rdReq && !sweepStart) begin
               if (!rd_in_range_c) begin
                  addr_err_d = 1'b1;
               end else if (out_free_c) begin
                  out_load_c = 1'b1;
                  out_addr_c = rdAddr;
               end
            end
         end
         S_LOAD: begin
            if (wr_hs_c) begin
               mem_we_c    = 1'b1;
               mem_waddr_c = ptr_q;
               if (ptr_q == LAST_ADDR) begin
                  state_d     = S_IDLE;
                  load_done_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + ADDR_WIDTH'(1);
               end
            end
         end
         S_SWEEP: begin
            // ptr holds the next address to fetch; fetched_last stops it at the final word
            if (out_free_c && !fetched_last_q) begin
               out_load_c = 1'b1;
               out_addr_c = ptr_q;
               out_last_c = (ptr_q == LAST_ADDR);
               if (ptr_q == LAST_ADDR) begin
                  fetched_last_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + ADDR_WIDTH'(1);
               end
            end
            if (rd_valid_q && rd_last_q && rdReady) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (out_load_c) begin
         rd_valid_d = 1'b1;
         rd_last_d  = out_last_c;
      end else if (rdReady) begin
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
      end
   end

   assign busy_d     = (state_d != S_IDLE);
   assign wr_ready_d = (state_d != S_SWEEP);

   // Control and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q          <= '0;
         fetched_last_q <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_last_q      <= 1'b0;
         load_done_q    <= 1'b0;
         addr_err_q     <= 1'b0;
         busy_q         <= 1'b0;
         wr_ready_q     <= 1'b1;
      end else begin
         ptr_q          <= ptr_d;
         fetched_last_q <= fetched_last_d;
         rd_valid_q     <= rd_valid_d;
         rd_last_q      <= rd_last_d;
         load_done_q    <= load_done_d;
         addr_err_q     <= addr_err_d;
         busy_q         <= busy_d;
         wr_ready_q     <= wr_ready_d;
      end
   end

   // Weight storage, deliberately not reset
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[mem_waddr_c] <= wrData;
      end
   end

   // Read data register; samples memory before a same-cycle write lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (out_load_c) begin
         rd_data_q <= mem[out_addr_c];
      end
   end

`ifdef LAYER_WEIGHT_PARITY_EN
   logic [LANES-1:0] par_mem [NODE_COUNT];
   logic [LANES-1:0] wr_par_c;
   logic             par_err_q;

   function automatic logic [LANES-1:0] lane_parity(input logic [DATA_W-1:0] w);
      logic [LANES-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         p[i] = ^w[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
      return p;
   endfunction

   always_comb begin
      wr_par_c    = lane_parity(wrData);
      wr_par_c[0] = wr_par_c[0] ^ wrParityFlip;
   end

   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         par_mem[mem_waddr_c] <= wr_par_c;
      end
   end

   // Parity check travels with the data into the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_q <= 1'b0;
      end else if (out_load_c) begin
         par_err_q <= |(par_mem[out_addr_c] ^ lane_parity(mem[out_addr_c]));
      end else if (rdReady) begin
         par_err_q <= 1'b0;
      end
   end

   assign parityError = par_err_q;
`else
   logic unused_parity_flip;
   assign unused_parity_flip = wrParityFlip;
   assign parityError        = 1'b0;
`endif

   assign wrReady   = wr_ready_q;
   assign rdValid   = rd_valid_q;
   assign rdData    = rd_data_q;
   assign rdLast    = rd_last_q;
   assign loadDone  = load_done_q;
   assign addrError = addr_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_layer_weight_bank.sv
// Bench for layer_weight_bank: word-level memory model plus an expected-beat queue checked every cycle.
module tb_layer_weight_bank;

   localparam int N  = 784;
   localparam int AW = 10;
   localparam int DW = 128;
`ifdef LAYER_WEIGHT_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           loadStart, sweepStart, wrValid, wrParityFlip, rdReq, rdReady;
   logic [AW-1:0]  wrAddr, rdAddr;
   logic [DW-1:0]  wrData;
   logic           wrReady, rdValid, rdLast, loadDone, addrError, busy, parityError;
   logic [DW-1:0]  rdData;

   layer_weight_bank dut (
      .clk(clk), .rst_n(rst_n), .loadStart(loadStart), .sweepStart(sweepStart),
      .wrValid(wrValid), .wrReady(wrReady), .wrAddr(wrAddr), .wrData(wrData),
      .wrParityFlip(wrParityFlip), .rdReq(rdReq), .rdAddr(rdAddr), .rdValid(rdValid),
      .rdReady(rdReady), .rdData(rdData), .rdLast(rdLast), .loadDone(loadDone),
      .addrError(addrError), .busy(busy), .parityError(parityError)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          par;
   } beat_t;

   logic [DW-1:0] m_mem  [N];
   logic          m_flip [N];
   beat_t         exp_q [$];
   int            n_cmp = 0;
   int            n_fail = 0;
   int            ld_pulses = 0;
   int            ae_pulses = 0;
   int            last_cnt = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic exp_par(input int a);
      return PAR_EN ? m_flip[a] : 1'b0;
   endfunction

   function automatic logic [DW-1:0] pat(input int i);
      logic [15:0] h;
      h = 16'(i * 37 + 5);
      return {8{h}} ^ 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
   endfunction

   // Every cycle: any valid beat must match the head of the expected stream
   always @(negedge clk) begin
      if (rst_n) begin
         if (loadDone) ld_pulses++;
         if (addrError) ae_pulses++;
         if (rdValid) begin
            if (exp_q.size() == 0) begin
               check("rd_spurious", DW'(rdValid), DW'(0));
            end else begin
               check("rd_data", rdData, exp_q[0].data);
               check("rd_last", DW'(rdLast), DW'(exp_q[0].last));
               check("rd_parity", DW'(parityError), DW'(exp_q[0].par));
               if (rdReady) begin
                  if (rdLast) last_cnt++;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d, input bit flip);
      wrValid = 1'b1; wrAddr = AW'(a); wrData = d; wrParityFlip = flip;
      step();
      wrValid = 1'b0; wrParityFlip = 1'b0;
      if (a < N) begin
         m_mem[a]  = d;
         m_flip[a] = flip;
      end
   endtask

   task automatic rd(input int a);
      if (a < N) exp_q.push_back(beat_t'{m_mem[a], 1'b0, exp_par(a)});
      rdReq = 1'b1; rdAddr = AW'(a);
      step();
      rdReq = 1'b0;
   endtask

   task automatic do_load(input bit with_sweep, input bit use_pat);
      logic [DW-1:0] d;
      loadStart = 1'b1; sweepStart = with_sweep;
      step();
      loadStart = 1'b0; sweepStart = 1'b0;
      check("load_busy", DW'(busy), DW'(1));
      check("load_wrready", DW'(wrReady), DW'(1));
      check("load_no_rdvalid", DW'(rdValid), DW'(0));
      for (int i = 0; i < N; i++) begin
         d = use_pat ? pat(i) : DW'(i);
         wrValid = 1'b1; wrAddr = AW'($urandom_range(0, 1023)); wrData = d; wrParityFlip = 1'b0;
         step();
         m_mem[i]  = d;
         m_flip[i] = 1'b0;
      end
      wrValid = 1'b0;
      check("load_done_pulse", DW'(loadDone), DW'(1));
      check("load_busy_after", DW'(busy), DW'(0));
      step();
      check("load_done_clear", DW'(loadDone), DW'(0));
   endtask

   task automatic do_sweep(input bit toggle, input int abort_at, output int cycles);
      for (int i = 0; i < N; i++) exp_q.push_back(beat_t'{m_mem[i], (i == N - 1), exp_par(i)});
      sweepStart = 1'b1; rdReady = 1'b1;
      step();
      sweepStart = 1'b0;
      check("sweep_latency", DW'(rdValid), DW'(1));
      cycles = 0;
      while (exp_q.size() != 0 && cycles < 4000) begin
         if (toggle) begin
            rdReady = cycles[0];
            wrValid = 1'($urandom_range(0, 1));
            wrAddr  = AW'($urandom_range(0, N - 1));
            wrData  = {4{$urandom()}};
         end
         step();
         cycles++;
         if (exp_q.size() != 0) begin
            check("sweep_wrready", DW'(wrReady), DW'(0));
            check("sweep_busy", DW'(busy), DW'(1));
         end
         if (abort_at > 0 && exp_q.size() == N - abort_at) break;
      end
      wrValid = 1'b0; rdReady = 1'b1;
      if (abort_at == 0) begin
         check("sweep_drained", DW'(exp_q.size()), DW'(0));
         check("sweep_busy_after", DW'(busy), DW'(0));
         exp_q.delete();
      end
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; loadStart = 1'b0; sweepStart = 1'b0; wrValid = 1'b0; wrParityFlip = 1'b0;
      rdReq = 1'b0; rdReady = 1'b0; wrAddr = '0; rdAddr = '0; wrData = '0;
      repeat (3) @(posedge clk);
      #3;
      check("rst_rdvalid", DW'(rdValid), DW'(0));
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_wrready", DW'(wrReady), DW'(1));
      rst_n = 1'b1;
      step();
      check("rst_rddata", rdData, DW'(0));
      check("rst_rdlast", DW'(rdLast), DW'(0));
      check("rst_loaddone", DW'(loadDone), DW'(0));
      check("rst_addrerr", DW'(addrError), DW'(0));
      check("rst_parity", DW'(parityError), DW'(0));

      // Single reads with backpressure
      wr(0, DW'(38), 1'b0);
      wr(1, DW'(52), 1'b0);
      rdReady = 1'b0;
      rd(0);
      for (int k = 0; k < 3; k++) begin
         check("rd0_valid_hold", DW'(rdValid), DW'(1));
         check("rd0_data_hold", rdData, DW'(38));
         if (k < 2) step();
      end
      rdReady = 1'b1;
      rd(1);
      check("rd1_data", rdData, DW'(52));
      step();
      check("rd_idle_after", DW'(rdValid), DW'(0));

      // Same-cycle read and write of one address returns the old word
      exp_q.push_back(beat_t'{m_mem[1], 1'b0, exp_par(1)});
      wrValid = 1'b1; wrAddr = AW'(1); wrData = DW'(99); rdReq = 1'b1; rdAddr = AW'(1);
      step();
      wrValid = 1'b0; rdReq = 1'b0;
      m_mem[1] = DW'(99); m_flip[1] = 1'b0;
      check("rw_same_old", rdData, DW'(52));
      rd(1);
      check("rw_same_new", rdData, DW'(99));
      step();

      // Bulk load with data=addr, then a full-rate sweep
      do_load(1'b0, 1'b0);
      do_sweep(1'b0, 0, cyc);
      check("sweep_cycles", DW'(cyc), DW'(784));
      check("sweep_last_once", DW'(last_cnt), DW'(1));
      check("load_pulse_once", DW'(ld_pulses), DW'(1));

      // Throttled sweep with stray write attempts
      do_sweep(1'b1, 0, cyc);
      step();

      // Out-of-range addresses
      wr(784, DW'(7), 1'b0);
      check("oob_wr_err", DW'(addrError), DW'(1));
      step();
      check("oob_err_clear", DW'(addrError), DW'(0));
      rd(800);
      check("oob_rd_err", DW'(addrError), DW'(1));
      check("oob_rd_novalid", DW'(rdValid), DW'(0));
      rd(783);
      check("oob_mem_intact", rdData, DW'(783));
      step();

      // loadStart and sweepStart together: load wins
      do_load(1'b1, 1'b1);
      do_sweep(1'b0, 0, cyc);

      // Reset during beat 100 of a sweep, then sweep again from 0
      do_sweep(1'b0, 100, cyc);
      check("abort_at_beat100", rdData, pat(100));
      rst_n = 1'b0;
      #1;
      check("abort_rdvalid", DW'(rdValid), DW'(0));
      check("abort_rdlast", DW'(rdLast), DW'(0));
      check("abort_busy", DW'(busy), DW'(0));
      exp_q.delete();
      step();
      rst_n = 1'b1;
      step();
      do_sweep(1'b0, 0, cyc);
      check("resweep_cycles", DW'(cyc), DW'(784));

      // Parity test hook
      wr(5, 128'h11_22_33_44_55_66_77_88_99_aa_bb_cc_dd_ee_ff_01, 1'b1);
      wr(4, 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10, 1'b0);
      rd(5);
      check("par_flip_5", DW'(parityError), DW'(PAR_EN));
      rd(4);
      check("par_clean_4", DW'(parityError), DW'(0));
      step();

      check("final_queue_empty", DW'(exp_q.size()), DW'(0));
      check("load_pulses_total", DW'(ld_pulses), DW'(2));
      check("addr_err_pulses", DW'(ae_pulses), DW'(2));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
